// File: rtl/fir_decim_out.sv
// Decimating averager for the FIR output stream: sums DECIM samples, rounds, rescales,
// saturates to OUT_W bits and queues results in a first-word-fall-through FIFO.
module fir_decim_out #(
  parameter int DECIM = 4,
  parameter int SHIFT = 4,
  parameter int OUT_W = 8,
  parameter int DEPTH = 8
) (
  input  logic                       Clk,
  input  logic                       Rst_n,
  input  logic [15:0]                Yin,
  input  logic                       Yin_valid,
  output logic [OUT_W-1:0]           Dout,
  output logic                       Dout_valid,
  input  logic                       Dout_ready,
  output logic [$clog2(DEPTH):0]     Level,
  output logic                       Overflow,
  input  logic                       Clr_ovf
);

  localparam int PW = $clog2(DECIM);
  localparam int AW = 16 + PW;
  localparam int RW = AW + 1;
  localparam int AWX = $clog2(DEPTH);
  localparam int LW = AWX + 1;
  localparam int RND_I = (2 ** SHIFT) / 2;
  localparam logic [RW-1:0] RND = RND_I[RW-1:0];
  localparam logic signed [RW-1:0] SAT_HI = RW'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [RW-1:0] SAT_LO = ~SAT_HI;
  localparam logic [PW-1:0] PH_LAST = PW'(DECIM - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] sum;
  logic signed [RW-1:0] rnd;
  logic signed [RW-1:0] shr;
  logic [OUT_W-1:0]     res;
  logic [PW-1:0]        phase;
  logic                 dump;

  logic [OUT_W-1:0] mem [DEPTH];
  logic [AWX-1:0]   wr_ptr;
  logic [AWX-1:0]   rd_ptr;
  logic [LW-1:0]    level;
  logic             full;
  logic             pop;
  logic             wr_en;
  logic             drop;

  assign sum  = acc + {{PW{Yin[15]}}, Yin};
  assign dump = Yin_valid && (phase == PH_LAST);

  // One guard bit above the sum keeps the rounding add from wrapping.
  assign rnd = {sum[AW-1], sum} + RND;
  assign shr = rnd >>> SHIFT;

  always_comb begin
    res = shr[OUT_W-1:0];
    if (shr > SAT_HI)
      res = SAT_HI[OUT_W-1:0];
    else if (shr < SAT_LO)
      res = SAT_LO[OUT_W-1:0];
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      acc   <= '0;
      phase <= '0;
    end else if (Yin_valid) begin
      if (dump) begin
        acc   <= '0;
        phase <= '0;
      end else begin
        acc   <= sum;
        phase <= phase + PW'(1);
      end
    end
  end

  assign full  = (level == LVL_FULL);
  assign pop   = (level != '0) && Dout_ready;
  // A pop frees the slot in the same edge, so a full FIFO still accepts a push then.
  assign wr_en = dump && (!full || pop);
  assign drop  = dump && full && !pop;

  always_ff @(posedge Clk) begin
    if (wr_en)
      mem[wr_ptr] <= res;
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      Overflow <= 1'b0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + AWX'(1);
      if (pop)
        rd_ptr <= rd_ptr + AWX'(1);
      case ({wr_en, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (drop)
        Overflow <= 1'b1;
      else if (Clr_ovf)
        Overflow <= 1'b0;
    end
  end

  assign Level      = level;
  assign Dout_valid = (level != '0);
  assign Dout       = Dout_valid ? mem[rd_ptr] : '0;

endmodule

// File: doc/fir_decim_out.md
Name: fir_decim_out

Overview:
- Downstream stage of the 4-tap FIR. Consumes the FIR's 16-bit signed output stream (one sample per clock) and averages/decimates it by DECIM.
- Each decimated result is rounded, rescaled and saturated to OUT_W bits.
- Results are buffered in a small first-word-fall-through FIFO behind a valid/ready handshake, so slower consumers can apply backpressure.

Parameters:
- DECIM, 4, samples summed per output (power of two, 2..16).
- SHIFT, 4, arithmetic right shift applied to the sum (0..8).
- OUT_W, 8, signed output width (4..16).
- DEPTH, 8, FIFO entries (power of two, 2..32).

Ports:
- Clk  input  1  rising-edge clock, same clock as the FIR.
- Rst_n  input  1  synchronous active-low reset, sampled on rising Clk.
- Yin  input  16  signed sample from the FIR Yout.
- Yin_valid  input  1  Yin is valid this cycle (tie high when fed directly from the FIR).
- Dout  output  OUT_W  signed decimated sample at the FIFO head.
- Dout_valid  output  1  FIFO non-empty.
- Dout_ready  input  1  consumer accepts Dout this cycle.
- Level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- Overflow  output  1  sticky: a result was dropped because the FIFO was full.
- Clr_ovf  input  1  clears Overflow.

Behaviour:
- Reset: while Rst_n=0 at a rising edge, all of the following are cleared: accumulator, phase counter, FIFO pointers, Level, Overflow, Dout_valid and Dout. Reset mid-accumulation discards the partial sum.
- Accumulator:
  - Signed, width 16+log2(DECIM).
  - Phase counter runs 0..DECIM-1 and advances only on Yin_valid=1. With Yin_valid=0, phase and accumulator hold.
- Dump:
  - On a valid sample with phase=DECIM-1: sum = acc + sign-extended Yin.
  - The result is pushed at the same edge; the accumulator reloads to 0 and phase wraps to 0.
  - For all other valid samples: acc <= acc + Yin.
- Scaling:
  - r = (sum + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT, i.e. arithmetic shift, round half toward +inf.
  - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Intermediates must be wide enough that the rounding add never wraps.
- Latency: Dout_valid rises in the cycle after the edge that captured the DECIM-th sample (FIFO previously empty).
- FIFO:
  - First-word-fall-through: Dout = head entry whenever Dout_valid=1, and Dout=0 when empty.
  - Pop occurs at an edge with Dout_valid=1 and Dout_ready=1.
  - Dout_ready while empty is ignored.
  - Read/write pointers wrap modulo DEPTH. Level = entries held, 0..DEPTH.
- Full:
  - A push while full with no pop drops the new result. FIFO contents and Level are unchanged, and Overflow <= 1.
  - A push and pop at the same edge while full are both accepted: Level stays DEPTH, no overflow.
  - A push and pop at the same edge while non-full and non-empty leave Level unchanged.
- Overflow: Clr_ovf=1 clears it at the next edge. If a drop and Clr_ovf occur at the same edge, the set wins.
- Dout, Dout_valid, Level and Overflow are all registered or derived directly from registers. There is no combinational path from Yin to any output.

Test Plan (defaults: DECIM=4, SHIFT=4, OUT_W=8, DEPTH=8):
- Basic: Yin=16 for 4 valid cycles, Dout_ready=1 -> one output Dout=4 (sum 64, +8, >>>4). Dout_valid high for exactly 1 cycle, starting 1 cycle after the 4th sample edge.
- Signed/rounding/saturation: 4 samples of -100 -> Dout=-25. 4 samples of 32767 -> Dout=127. 4 samples of -32768 -> Dout=-128. Samples 1,1,1,4 (sum 7) -> Dout=0; samples 2,2,2,2 (sum 8) -> Dout=1.
- Gaps: Yin_valid pattern 1,0,0,1,1,0,1 with Yin=32 on valid cycles -> a single output of 8, produced after the 4th valid sample. Phase holds during the gaps.
- Backpressure/overflow: Dout_ready=0 across 9 dumps -> Level=8, Overflow=1, 9th result lost. Then Dout_ready=1 drains exactly the first 8 results in order, with Level counting down to 0. Clr_ovf pulse then clears Overflow.
- Full with simultaneous push/pop: FIFO at 8, Dout_ready=1 on the same edge as a dump -> Level stays 8, Overflow stays 0, and the output order is preserved.
- Reset mid-operation: Rst_n=0 for 1 cycle after 2 of 4 samples, with 3 entries queued -> Level=0, Dout_valid=0, Dout=0. The next 4 samples of 16 yield Dout=4, showing no residue from the partial sum.
